exu_disp_oitf: RTL and testbench
================================

Name: exu_disp_oitf

Overview:
Parametrised dispatch stage with an integrated outstanding-instruction track FIFO (OITF). It accepts decoded instructions from the IFU/decode side and forwards every instruction to the ALU. It allocates an OITF entry for each long-pipe instruction (LSU, mul/div). It stalls dispatch on RAW/WAW hazards against in-flight long-pipe destinations and retires entries in order on long-pipe writeback.

Parameters:
XLEN, 32, operand/immediate width
PC_SIZE, 32, PC width
RFIDX_W, 5, register index width
DECINFO_W, 32, decode info bus width
OITF_DEPTH, 2, OITF entries; power of 2, >=2
ITAG_W, 1, tag width; must equal log2(OITF_DEPTH)
WAW_CHK, 1, 1 = rd-vs-OITF WAW check enabled; 0 = RAW only

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
disp_i_valid  in  1  instruction valid from decode
disp_i_ready  out  1  dispatch accepts instruction
disp_i_rs1en, disp_i_rs2en, disp_i_rdwen  in  1 each  operand/dest enables
disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx  in  RFIDX_W each  register indices
disp_i_rs1, disp_i_rs2, disp_i_imm  in  XLEN each  operands/immediate
disp_i_info  in  DECINFO_W  decode info
disp_i_pc  in  PC_SIZE  instruction PC
disp_i_ilegl  in  1  illegal-instruction flag
disp_o_alu_valid  out  1  valid to ALU
disp_o_alu_ready  in  1  ALU accepts
disp_o_alu_longpipe  in  1  ALU flags current instruction as multi-cycle
disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_imm  out  XLEN each  pass-through
disp_o_alu_rdwen  out  1; disp_o_alu_rdidx  out  RFIDX_W; disp_o_alu_info  out  DECINFO_W; disp_o_alu_pc  out  PC_SIZE; disp_o_alu_ilegl  out  1  pass-through
disp_o_alu_itag  out  ITAG_W  OITF write pointer (tag of allocated entry)
oitf_ret_ena  in  1  retire oldest OITF entry (long-pipe writeback done)
oitf_ret_ptr  out  ITAG_W  tag of oldest entry
oitf_ret_rdwen  out  1; oitf_ret_rdidx  out  RFIDX_W  oldest entry destination
oitf_empty  out  1  no outstanding entries
oitf_full  out  1  all entries valid

Behaviour:
- State: per-entry vld, rdwen, rdidx; wptr, rptr (ITAG_W, natural wrap at OITF_DEPTH).
- Reset (rst_n=0 at posedge): vld all 0, wptr=rptr=0 -> oitf_empty=1, oitf_full=0, itag=0, ret_ptr=0. Entry payload is don't-care.
- oitf_empty = ~|vld; oitf_full = vld[wptr].
- Hazard match per entry i: vld[i] & rdwen[i] & rdidx[i]==idx & idx!=0, where idx is rs1idx (gated by rs1en), rs2idx (gated by rs2en), or rdidx (gated by rdwen and WAW_CHK).
- dep = OR over all entries and all three checks. It uses registered state only: a same-cycle retire does not unblock, and a same-cycle alloc becomes visible next cycle.
- cond = ~dep & (disp_o_alu_longpipe ? ~oitf_full : 1).
- disp_o_alu_valid = disp_i_valid & cond; disp_i_ready = disp_o_alu_ready & cond. Both are combinational, 0-cycle latency.
- All payload outputs are combinational pass-through.
- alloc = disp_o_alu_valid & disp_o_alu_ready & disp_o_alu_longpipe.
  - On alloc: vld[wptr]<=1, rdwen/rdidx captured, wptr<=wptr+1.
  - disp_o_alu_itag = wptr in the same cycle.
- retire = oitf_ret_ena & ~oitf_empty.
  - On retire: vld[rptr]<=0, rptr<=rptr+1.
  - oitf_ret_ena while empty is ignored; no state change.
- Simultaneous alloc+retire:
  - Both take effect; occupancy unchanged.
  - When full, alloc is impossible (cond=0), so no overwrite occurs.
  - Same index with both set is impossible unless empty or full: empty blocks retire, full blocks alloc.
- x0 (idx 0) never creates a dependency.
- Non-longpipe instructions never touch OITF state and never wait on full.
- Reset mid-operation discards all entries; in-flight retires after reset are ignored until a new alloc occurs.

Test Plan:
- Reset, then longpipe load rd=x5 accepted (itag=0) -> next cycle oitf_empty=0. Subsequent add rs1=x5 sees disp_i_ready=0 and alu_valid=0 until oitf_ret_ena pulses. The add dispatches the cycle after the retire, not the same cycle.
- OITF_DEPTH=2: two longpipe allocs (itag 0,1) -> oitf_full=1. Third longpipe (independent regs) is stalled while a non-longpipe independent add still dispatches. Retire -> third accepted with itag=0 (wrap).
- Full OITF, same cycle retire + stalled longpipe -> no alloc that cycle; alloc next cycle; occupancy stays 2.
- Entry rd=x0 with rdwen=1 outstanding, instruction rs1=x0 -> no stall. WAW_CHK=1: instruction rd=x7 with outstanding rd=x7 stalls; WAW_CHK=0: it dispatches.
- oitf_ret_ena while empty -> rptr stays 0, oitf_empty stays 1.
- Empty OITF with simultaneous alloc -> entry allocated, no retire. rst_n=0 with 2 entries -> next cycle empty, itag=0, stalled instruction released.

Source files
------------

// File: rtl/exu_disp_oitf.sv
// exu_disp_oitf: dispatch stage with outstanding-instruction track FIFO and RAW/WAW hazard stall
module exu_disp_oitf #(
    parameter int XLEN       = 32,
    parameter int PC_SIZE    = 32,
    parameter int RFIDX_W    = 5,
    parameter int DECINFO_W  = 32,
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_W     = 1,
    parameter int WAW_CHK    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_i_valid,
    output logic                 disp_i_ready,
    input  logic                 disp_i_rs1en,
    input  logic                 disp_i_rs2en,
    input  logic                 disp_i_rdwen,
    input  logic [RFIDX_W-1:0]   disp_i_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_i_rs2idx,
    input  logic [RFIDX_W-1:0]   disp_i_rdidx,
    input  logic [XLEN-1:0]      disp_i_rs1,
    input  logic [XLEN-1:0]      disp_i_rs2,
    input  logic [XLEN-1:0]      disp_i_imm,
    input  logic [DECINFO_W-1:0] disp_i_info,
    input  logic [PC_SIZE-1:0]   disp_i_pc,
    input  logic                 disp_i_ilegl,
    output logic                 disp_o_alu_valid,
    input  logic                 disp_o_alu_ready,
    input  logic                 disp_o_alu_longpipe,
    output logic [XLEN-1:0]      disp_o_alu_rs1,
    output logic [XLEN-1:0]      disp_o_alu_rs2,
    output logic [XLEN-1:0]      disp_o_alu_imm,
    output logic                 disp_o_alu_rdwen,
    output logic [RFIDX_W-1:0]   disp_o_alu_rdidx,
    output logic [DECINFO_W-1:0] disp_o_alu_info,
    output logic [PC_SIZE-1:0]   disp_o_alu_pc,
    output logic                 disp_o_alu_ilegl,
    output logic [ITAG_W-1:0]    disp_o_alu_itag,
    input  logic                 oitf_ret_ena,
    output logic [ITAG_W-1:0]    oitf_ret_ptr,
    output logic                 oitf_ret_rdwen,
    output logic [RFIDX_W-1:0]   oitf_ret_rdidx,
    output logic                 oitf_empty,
    output logic                 oitf_full
);
    logic [OITF_DEPTH-1:0] vld;
    logic [OITF_DEPTH-1:0] ent_rdwen;
    logic [RFIDX_W-1:0]    ent_rdidx [OITF_DEPTH];
    logic [ITAG_W-1:0]     wptr;
    logic [ITAG_W-1:0]     rptr;
    logic                  dep;
    logic                  cond;
    logic                  alloc;
    logic                  retire;

    assign oitf_empty       = ~|vld;
    assign oitf_full        = vld[wptr];
    assign cond             = ~dep & (disp_o_alu_longpipe ? ~oitf_full : 1'b1);
    assign disp_o_alu_valid = disp_i_valid & cond;
    assign disp_i_ready     = disp_o_alu_ready & cond;
    assign alloc            = disp_o_alu_valid & disp_o_alu_ready & disp_o_alu_longpipe;
    assign retire           = oitf_ret_ena & ~oitf_empty;
    assign disp_o_alu_rs1   = disp_i_rs1;
    assign disp_o_alu_rs2   = disp_i_rs2;
    assign disp_o_alu_imm   = disp_i_imm;
    assign disp_o_alu_rdwen = disp_i_rdwen;
    assign disp_o_alu_rdidx = disp_i_rdidx;
    assign disp_o_alu_info  = disp_i_info;
    assign disp_o_alu_pc    = disp_i_pc;
    assign disp_o_alu_ilegl = disp_i_ilegl;
    assign disp_o_alu_itag  = wptr;
    assign oitf_ret_ptr     = rptr;
    assign oitf_ret_rdwen   = ent_rdwen[rptr];
    assign oitf_ret_rdidx   = ent_rdidx[rptr];

    // Hazard detect: any live entry writing a non-x0 register the new instruction reads (or writes, when WAW is on)
    always_comb begin
        dep = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            dep = dep | (vld[i] & ent_rdwen[i] & (
                  (disp_i_rs1en & (disp_i_rs1idx == ent_rdidx[i]) & (|disp_i_rs1idx))
                | (disp_i_rs2en & (disp_i_rs2idx == ent_rdidx[i]) & (|disp_i_rs2idx))
                | ((WAW_CHK != 0) & disp_i_rdwen & (disp_i_rdidx == ent_rdidx[i]) & (|disp_i_rdidx))));
        end
    end

    // Valid bits and pointers: allocate at wptr, retire oldest at rptr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (alloc) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            if (retire) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
        end
    end

    // Entry payload needs no reset; it is only observed while its valid bit is set
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_rdwen[wptr] <= disp_i_rdwen;
            ent_rdidx[wptr] <= disp_i_rdidx;
        end
    end
endmodule

// File: tb/tb_exu_disp_oitf.sv
// tb_exu_disp_oitf: queue-model checker plus directed scenarios, WAW-on and WAW-off instances in parallel
module tb_exu_disp_oitf;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, rs1en = 1'b0, rs2en = 1'b0, rdwen = 1'b0, ilegl = 1'b0;
    logic [4:0]  rs1idx = '0, rs2idx = '0, rdidx = '0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0, info = '0, pc = '0;
    logic        alu_ready = 1'b1, lp = 1'b0, ret_ena = 1'b0;

    logic [1:0]  o_valid, i_ready, emp, ful, r_rdwen, a_rdwen, a_ilegl;
    logic [0:0]  itag [2];
    logic [0:0]  r_ptr [2];
    logic [4:0]  r_rdidx [2];
    logic [4:0]  a_rdidx [2];
    logic [31:0] a_rs1 [2];
    logic [31:0] a_rs2 [2];
    logic [31:0] a_imm [2];
    logic [31:0] a_info [2];
    logic [31:0] a_pc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exu_disp_oitf #(.OITF_DEPTH(D), .ITAG_W(1), .WAW_CHK(g == 0 ? 1 : 0)) u (
            .clk(clk), .rst_n(rst_n),
            .disp_i_valid(i_valid), .disp_i_ready(i_ready[g]),
            .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rdwen(rdwen),
            .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rdidx(rdidx),
            .disp_i_rs1(rs1), .disp_i_rs2(rs2), .disp_i_imm(imm),
            .disp_i_info(info), .disp_i_pc(pc), .disp_i_ilegl(ilegl),
            .disp_o_alu_valid(o_valid[g]), .disp_o_alu_ready(alu_ready),
            .disp_o_alu_longpipe(lp),
            .disp_o_alu_rs1(a_rs1[g]), .disp_o_alu_rs2(a_rs2[g]), .disp_o_alu_imm(a_imm[g]),
            .disp_o_alu_rdwen(a_rdwen[g]), .disp_o_alu_rdidx(a_rdidx[g]),
            .disp_o_alu_info(a_info[g]), .disp_o_alu_pc(a_pc[g]), .disp_o_alu_ilegl(a_ilegl[g]),
            .disp_o_alu_itag(itag[g]),
            .oitf_ret_ena(ret_ena), .oitf_ret_ptr(r_ptr[g]),
            .oitf_ret_rdwen(r_rdwen[g]), .oitf_ret_rdidx(r_rdidx[g]),
            .oitf_empty(emp[g]), .oitf_full(ful[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: in-order list of outstanding {rdwen, rdidx} plus alloc/retire counts, one per instance
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int ac[2];
    int rc[2];

    function automatic int qsize(int m);
        return m != 0 ? q1.size() : q0.size();
    endfunction

    function automatic logic [5:0] qat(int m, int i);
        return m != 0 ? q1[i] : q0[i];
    endfunction

    function automatic bit has_dep(int m);
        logic [5:0] e;
        for (int i = 0; i < qsize(m); i++) begin
            e = qat(m, i);
            if (e[5] && e[4:0] != 0 && ((rs1en && rs1idx == e[4:0]) || (rs2en && rs2idx == e[4:0])
                || (m == 0 && rdwen && rdidx == e[4:0])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin : cmp
        bit armed;
        bit ae[2];
        bit re[2];
        armed = 1'b0;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                int n;
                bit ok;
                ae[m] = 1'b0;
                re[m] = 1'b0;
                if (armed) begin
                    n  = qsize(m);
                    ok = !has_dep(m) && !(lp && n == D);
                    chk($sformatf("m%0d valid", m), o_valid[m], i_valid & ok);
                    chk($sformatf("m%0d ready", m), i_ready[m], alu_ready & ok);
                    chk($sformatf("m%0d empty", m), emp[m], n == 0);
                    chk($sformatf("m%0d full", m), ful[m], n == D);
                    chk($sformatf("m%0d itag", m), itag[m], ac[m] % D);
                    chk($sformatf("m%0d ret_ptr", m), r_ptr[m], rc[m] % D);
                    if (n > 0) begin
                        chk($sformatf("m%0d ret_rdwen", m), r_rdwen[m], qat(m, 0) >> 5);
                        chk($sformatf("m%0d ret_rdidx", m), r_rdidx[m], qat(m, 0) & 6'h1f);
                    end
                    chk($sformatf("m%0d pass", m), {a_rs1[m] ^ a_rs2[m] ^ a_imm[m] ^ a_info[m] ^ a_pc[m]},
                        rs1 ^ rs2 ^ imm ^ info ^ pc);
                    chk($sformatf("m%0d pass_rd", m), {a_ilegl[m], a_rdwen[m], a_rdidx[m]}, {ilegl, rdwen, rdidx});
                    ae[m] = i_valid && ok && alu_ready && lp;
                    re[m] = ret_ena && n > 0;
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                ac = '{0, 0};
                rc = '{0, 0};
                armed = 1'b1;
            end else if (armed) begin
                for (int m = 0; m < 2; m++) begin
                    if (re[m]) begin
                        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        rc[m]++;
                    end
                    if (ae[m]) begin
                        if (m == 0) q0.push_back({rdwen, rdidx}); else q1.push_back({rdwen, rdidx});
                        ac[m]++;
                    end
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic put(bit v, bit l, bit e1, logic [4:0] s1, bit e2, logic [4:0] s2, bit w, logic [4:0] d);
        i_valid = v; lp = l; rs1en = e1; rs1idx = s1; rs2en = e2; rs2idx = s2; rdwen = w; rdidx = d;
        rs1 = $urandom; rs2 = $urandom; imm = $urandom; info = $urandom; pc = $urandom; ilegl = 1'($urandom);
    endtask

    initial begin
        go(); go();
        rst_n = 1'b1;
        #1;
        chk("rst empty", emp[0], 1); chk("rst full", ful[0], 0);
        chk("rst itag", itag[0], 0); chk("rst ret_ptr", r_ptr[0], 0);
        ret_ena = 1'b1;
        go(); ret_ena = 1'b0; #1;
        chk("empty retire ptr", r_ptr[0], 0); chk("empty retire empty", emp[0], 1);
        // load x5, dependent add waits for retire and goes the cycle after
        put(1, 1, 0, 0, 0, 0, 1, 5); #1;
        chk("load valid", o_valid[0], 1); chk("load ready", i_ready[0], 1); chk("load itag", itag[0], 0);
        go(); put(1, 0, 1, 5, 0, 0, 1, 6); #1;
        chk("raw empty", emp[0], 0); chk("raw valid", o_valid[0], 0); chk("raw ready", i_ready[0], 0);
        go(); #1; chk("raw hold", i_ready[0], 0);
        ret_ena = 1'b1; #1; chk("raw ret same cyc", i_ready[0], 0);
        go(); ret_ena = 1'b0; #1;
        chk("raw release ready", i_ready[0], 1); chk("raw release valid", o_valid[0], 1);
        go(); put(0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        go(); rst_n = 1'b1;
        // fill, stall third longpipe, non-longpipe bypasses, wrap on retire
        put(1, 1, 0, 0, 0, 0, 1, 1); #1; chk("fill0 itag", itag[0], 0);
        go(); put(1, 1, 0, 0, 0, 0, 1, 2); #1; chk("fill1 itag", itag[0], 1);
        go(); put(1, 1, 1, 4, 0, 0, 1, 3); #1; chk("full", ful[0], 1); chk("full lp stall", o_valid[0], 0);
        go(); put(1, 0, 1, 4, 0, 0, 1, 6); #1; chk("full alu go", o_valid[0], 1);
        go(); put(1, 1, 1, 4, 0, 0, 1, 3); ret_ena = 1'b1; #1; chk("full ret same cyc", o_valid[0], 0);
        go(); ret_ena = 1'b0; #1; chk("wrap valid", o_valid[0], 1); chk("wrap itag", itag[0], 0);
        go(); put(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("occupancy 2", ful[0], 1);
        ret_ena = 1'b1;
        go(); go(); ret_ena = 1'b0; #1;
        chk("drained", emp[0], 1); chk("drained ret_ptr", r_ptr[0], 1);
        put(1, 1, 0, 0, 0, 0, 1, 8); alu_ready = 1'b0; #1;
        chk("noready valid", o_valid[0], 1); chk("noready ready", i_ready[0], 0);
        go(); alu_ready = 1'b1; put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("noready no alloc", emp[0], 1); chk("noready itag", itag[0], 1);
        // x0 never blocks; WAW differs between instances
        put(1, 1, 0, 0, 0, 0, 1, 0);
        go(); put(1, 0, 1, 0, 0, 0, 1, 0); #1; chk("x0 entry", emp[0], 0); chk("x0 no stall", o_valid[0], 1);
        go(); put(1, 1, 0, 0, 0, 0, 1, 7); #1; chk("x7 alloc", o_valid[0], 1);
        go(); put(1, 0, 0, 0, 0, 0, 1, 7); #1;
        chk("waw on stall", o_valid[0], 0); chk("waw off go", o_valid[1], 1); chk("waw full", ful[1], 1);
        // reset mid-operation releases a stalled instruction; stale retire ignored; alloc+retire on empty
        go(); put(1, 0, 1, 7, 0, 0, 0, 0); #1; chk("stall pre-rst", o_valid[0] | o_valid[1], 0);
        rst_n = 1'b0;
        go(); rst_n = 1'b1; #1;
        chk("rst2 empty", emp[0], 1); chk("rst2 itag", itag[0], 0); chk("rst2 release", o_valid[0], 1);
        go(); put(0, 0, 0, 0, 0, 0, 0, 0); ret_ena = 1'b1; #1; chk("stale ret", emp[0], 1);
        go(); put(1, 1, 0, 0, 0, 0, 1, 9); #1; chk("alloc+ret empty", o_valid[0], 1);
        go(); ret_ena = 1'b0; put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("ae empty", emp[0], 0); chk("ae rdidx", r_rdidx[0], 9); chk("ae rdwen", r_rdwen[0], 1);
        chk("ae ret_ptr", r_ptr[0], 0); chk("ae itag", itag[0], 1);
        go(); go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
